// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Writer-side front end for the 32x32 integer register file. Collects
//   results from the ALU and the load path, queues them in arrival order
//   (mem before alu on a shared cycle) and issues at most one registered
//   write per cycle. Exports a busy vector for decode stall checks.
//
//   Optional build macro: WB_BYPASS_EN
//     When defined, a result arriving while the FIFO is empty goes straight
//     to the output registers at the accepting edge instead of being queued.
//
//   Ports
//     clk, nRST                          clock, async active-low reset
//     alu_valid/alu_index/alu_data       ALU result, alu_ready handshake
//     mem_valid/mem_index/mem_data       load result, mem_ready handshake
//     reg_write/write_index/write_data   register-file write port (registered)
//     busy[31:0]                         register has a queued or in-flight write
//     count                              FIFO occupancy
module writeback_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_index,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_index,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  output logic                     reg_write,
  output logic [4:0]               write_index,
  output logic [DATA_W-1:0]        write_data,
  output logic [31:0]              busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M2_C = CW'(DEPTH - 2);

  // FIFO storage (not reset: validity comes from the pointers/count)
  logic [4:0]        idx_q [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              rw_q;
  logic [4:0]        wi_q;
  logic [DATA_W-1:0] wd_q;

  logic mem_push, alu_push, pop;
  logic byp_mem, byp_alu;
  logic enq_mem, enq_alu;
  logic [PW-1:0] alu_slot;

  // Ready looks only at registered occupancy; a pop this cycle earns no credit.
  assign mem_ready = (count_q < DEPTH_C);
  assign alu_ready = (count_q <= DEPTH_M2_C) | (mem_ready & ~mem_valid);

  // x0 results complete the handshake but are dropped here.
  assign mem_push = mem_valid & mem_ready & (mem_index != 5'd0);
  assign alu_push = alu_valid & alu_ready & (alu_index != 5'd0);
  assign pop      = (count_q != '0);

`ifdef WB_BYPASS_EN
  // Only possible when nothing is queued (pop low); mem has priority.
  assign byp_mem = ~pop & mem_push;
  assign byp_alu = ~pop & ~mem_push & alu_push;
`else
  assign byp_mem = 1'b0;
  assign byp_alu = 1'b0;
`endif

  assign enq_mem  = mem_push & ~byp_mem;
  assign enq_alu  = alu_push & ~byp_alu;
  // alu lands behind the mem entry when both are enqueued.
  assign alu_slot = wr_ptr_q + PW'(enq_mem);

  assign count_d  = count_q + CW'(enq_mem) + CW'(enq_alu) - CW'(pop);
  assign wr_ptr_d = wr_ptr_q + PW'(enq_mem) + PW'(enq_alu);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);

  always_ff @(posedge clk) begin
    if (enq_mem) begin
      idx_q[wr_ptr_q] <= mem_index;
      dat_q[wr_ptr_q] <= mem_data;
    end
    if (enq_alu) begin
      idx_q[alu_slot] <= alu_index;
      dat_q[alu_slot] <= alu_data;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rw_q     <= 1'b0;
      wi_q     <= '0;
      wd_q     <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (pop) begin
        rw_q <= 1'b1;
        wi_q <= idx_q[rd_ptr_q];
        wd_q <= dat_q[rd_ptr_q];
      end else if (byp_mem) begin
        rw_q <= 1'b1;
        wi_q <= mem_index;
        wd_q <= mem_data;
      end else if (byp_alu) begin
        rw_q <= 1'b1;
        wi_q <= alu_index;
        wd_q <= alu_data;
      end else begin
        rw_q <= 1'b0;  // index/data hold their last values
      end
    end
  end

  // Entry i is live when its distance from the read pointer (mod DEPTH)
  // is below the occupancy.
  logic [PW-1:0]    ent_off [DEPTH];
  logic [DEPTH-1:0] ent_vld;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_off[i] = PW'(i) - rd_ptr_q;
    assign ent_vld[i] = ({1'b0, ent_off[i]} < count_q);
  end

  logic [31:0] busy_d;
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i]) busy_d[idx_q[i]] = 1'b1;
    if (rw_q) busy_d[wi_q] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign busy        = busy_d;
  assign count       = count_q;
  assign reg_write   = rw_q;
  assign write_index = wi_q;
  assign write_data  = wd_q;

endmodule
